sram_bus_arbiter: RTL
=====================

Name: sram_bus_arbiter

Overview:
Shares the single external base SRAM between the instruction-fetch port (read-only) and the MEM-stage data port (read/write, byte-lane masked). Sequences each SRAM access as a multi-cycle transaction with configurable wait states and a write-recovery cycle. Returns per-port acknowledge pulses and registered read data. Raises per-port stall requests to the pipeline controller while a request is pending.

Parameters:
WAIT_CYCLES, 1, extra cycles each access phase is held beyond the first (access phase = WAIT_CYCLES+1 cycles); legal 0..7
ADDR_W, 20, SRAM word-address width; ram_addr = byte_addr[ADDR_W+1:2]

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
if_req  input  1  fetch request, level, held until if_ack
if_addr  input  32  fetch byte address
if_rdata  output  32  fetch read data, valid with if_ack, held until next if_ack
if_ack  output  1  one-cycle completion pulse, registered
if_stall  output  1  if_req & ~if_ack, combinational
dm_ce  input  1  data request, level, held until dm_ack
dm_we_n  input  1  0 = write, 1 = read
dm_sel_n  input  4  active-low byte enables; 4'b0000 = word
dm_addr  input  32  data byte address
dm_wdata  input  32  write data
dm_rdata  output  32  read data, valid with dm_ack, held until next dm_ack
dm_ack  output  1  one-cycle completion pulse, registered
dm_stall  output  1  dm_ce & ~dm_ack, combinational
ram_addr  output  ADDR_W  SRAM word address
ram_wdata  output  32  SRAM write data
ram_rdata  input  32  SRAM read data
ram_ce_n  output  1  chip enable, active-low
ram_oe_n  output  1  output enable, active-low
ram_we_n  output  1  write enable, active-low
ram_be_n  output  4  byte enables, active-low

Behaviour:
- Reset (sync, any state incl. mid-access): state IDLE, counter 0; ram_ce_n=1, ram_oe_n=1, ram_we_n=1, ram_be_n=4'b1111, ram_addr=0, ram_wdata=0; if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0; grant_last=IF. Interrupted access is never acked; requester re-issues.
- All ram_* outputs registered; driven from latched request, stable for the whole transaction.
- States: IDLE, RD, WR, WR_HOLD.
- IDLE: SRAM idle (all enables high). Arbitrate: dm_ce wins over if_req (fixed priority unless ROUND_ROBIN_EN). At grant, latch port id, address, wdata, be_n (dm_sel_n for data, 4'b0000 for fetch). dm read or fetch -> RD; dm write -> WR. A port whose ack is high this cycle is excluded from arbitration (turnaround, prevents double grant).
- RD: ce_n=0, oe_n=0, we_n=1, for WAIT_CYCLES+1 cycles. On the last cycle, sample ram_rdata into the granted port's rdata register, pulse its ack next cycle, return to IDLE.
- WR: ce_n=0, oe_n=1, we_n=0, for WAIT_CYCLES+1 cycles -> WR_HOLD.
- WR_HOLD: 1 cycle, we_n=1, ce_n=0, addr/data/be held (hold time); then ack, IDLE.
- Latency from first IDLE cycle with request (T): read ack at T+2+WAIT_CYCLES; write ack at T+3+WAIT_CYCLES.
- Request inputs changing after grant are ignored until the next IDLE.
- Write with dm_sel_n=4'b1111: full write cycle runs, be_n all high, no bytes modified, ack issued.
- Read data returned as the full word; byte extraction/extension is done by the requester.
- Counter width 3 bits, reloads to 0 on every state entry.

Optional Feature:
ROUND_ROBIN_EN: when defined, if both ports request in the same IDLE cycle, the port not granted last (grant_last) wins, so fetch cannot starve under back-to-back data traffic. When undefined, data always wins; grant_last is not implemented.

Test Plan:
- Reset mid-RD (WAIT_CYCLES=1, rst high in 2nd access cycle) -> next cycle ram_ce_n=1, ram_oe_n=1, ram_be_n=4'b1111, no ack ever issued for that access.
- Fetch read, if_addr=0x0000_0010, ram_rdata=0xDEADBEEF, WAIT_CYCLES=1 -> ram_addr=0x00004, oe_n low 2 cycles, if_ack pulse at T+3, if_rdata=0xDEADBEEF held afterwards.
- Data byte store, dm_addr=0x0000_0103, dm_sel_n=4'b0111, dm_wdata=0x5A000000 -> ram_addr=0x00040, ram_be_n=4'b0111, we_n low 2 cycles, 1 hold cycle, dm_ack at T+4.
- Simultaneous if_req and dm_ce read, fixed priority -> data served first (dm_ack at T+3), fetch granted next IDLE, if_stall high throughout.
- ROUND_ROBIN_EN defined, dm_ce held continuously with back-to-back reads, if_req high -> grants alternate dm, if, dm; if_ack within 2 transactions.
- WAIT_CYCLES=0 sweep: read ack at T+2, write ack at T+3; dm_sel_n=4'b1111 write completes with ram_be_n=4'b1111.

Source files
------------

// File: rtl/sram_bus_arbiter_if.sv
// Bus bundle for the base-SRAM arbiter: fetch port, data port and SRAM pins.
//   if_*  : instruction-fetch request (read-only) and its ack/data/stall
//   dm_*  : MEM-stage data request (read/write, active-low byte lanes)
//   ram_* : external asynchronous SRAM pins (active-low controls)
// Modports:
//   slave  : the arbiter's view (takes requests, drives the SRAM pins)
//   master : the pipeline/SRAM side (issues requests, returns SRAM data)
interface sram_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 20
);

  // fetch port
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_ack;
  logic              if_stall;

  // data port
  logic              dm_ce;
  logic              dm_we_n;
  logic [3:0]        dm_sel_n;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_ack;
  logic              dm_stall;

  // SRAM pins
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_ce_n;
  logic              ram_oe_n;
  logic              ram_we_n;
  logic [3:0]        ram_be_n;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack, if_stall,
    input  dm_ce, dm_we_n, dm_sel_n, dm_addr, dm_wdata,
    output dm_rdata, dm_ack, dm_stall,
    output ram_addr, ram_wdata, ram_ce_n, ram_oe_n, ram_we_n, ram_be_n,
    input  ram_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack, if_stall,
    output dm_ce, dm_we_n, dm_sel_n, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack, dm_stall,
    input  ram_addr, ram_wdata, ram_ce_n, ram_oe_n, ram_we_n, ram_be_n,
    output ram_rdata
  );

endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares the single external base SRAM between the instruction-fetch port and
// the MEM-stage data port. Each access runs as a multi-cycle transaction:
//   read : RD for WAIT_CYCLES+1 cycles, data sampled on the last one
//   write: WR for WAIT_CYCLES+1 cycles, then one WR_HOLD cycle (we_n high,
//          address/data/byte enables still driven) for hold time
// Acks are one-cycle registered pulses; read data is registered and held until
// the next ack of the same port. Stalls are combinational (req & ~ack).
//
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset; an interrupted access is never acked
//   bus  : sram_bus_arbiter_if.slave (fetch port, data port, SRAM pins)
//
// Parameters:
//   WAIT_CYCLES : extra cycles per access phase (0..7)
//   ADDR_W      : SRAM word-address width; ram_addr = byte_addr[ADDR_W+1:2]
//
// Build option:
//   ROUND_ROBIN_EN : when defined, a simultaneous request is granted to the
//                    port not granted last; otherwise the data port always wins.
module sram_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 20
) (
  input logic                clk,
  input logic                rst,
  sram_bus_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    WR      = 2'd2,
    WR_HOLD = 2'd3
  } state_t;

  state_t            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              port_q,      port_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic [3:0]        ram_be_n_q,  ram_be_n_d;
  logic              ram_ce_n_q,  ram_ce_n_d;
  logic              ram_oe_n_q,  ram_oe_n_d;
  logic              ram_we_n_q,  ram_we_n_d;
  logic              if_ack_q,    if_ack_d;
  logic              dm_ack_q,    dm_ack_d;
  logic [31:0]       if_rdata_q,  if_rdata_d;
  logic [31:0]       dm_rdata_q,  dm_rdata_d;

  logic              if_cand;
  logic              dm_cand;
  logic              grant_dm;
  logic              grant_if;

  // Address bits outside the SRAM word window are intentionally dropped.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                              bus.dm_addr[31:ADDR_W+2], bus.dm_addr[1:0]};

  // A port being acked this cycle still holds its request; keep it out of
  // arbitration so the same request is not granted twice.
  assign if_cand = bus.if_req & ~if_ack_q;
  assign dm_cand = bus.dm_ce  & ~dm_ack_q;

`ifdef ROUND_ROBIN_EN
  logic grant_last_q, grant_last_d;

  // On a tie, the port that did not win last time takes the bus.
  assign grant_dm = dm_cand & (~if_cand | (grant_last_q == PORT_IF));
`else
  assign grant_dm = dm_cand;
`endif
  assign grant_if = if_cand & ~grant_dm;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      port_q      <= PORT_IF;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_be_n_q  <= 4'b1111;
      ram_ce_n_q  <= 1'b1;
      ram_oe_n_q  <= 1'b1;
      ram_we_n_q  <= 1'b1;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      port_q      <= port_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_be_n_q  <= ram_be_n_d;
      ram_ce_n_q  <= ram_ce_n_d;
      ram_oe_n_q  <= ram_oe_n_d;
      ram_we_n_q  <= ram_we_n_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

`ifdef ROUND_ROBIN_EN
  // Last-granted port; starts as fetch so the data port wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_last_q <= PORT_IF;
    end else begin
      grant_last_q <= grant_last_d;
    end
  end
`endif

  // Next-state, latched request and next SRAM pin values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    port_d      = port_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_be_n_d  = ram_be_n_q;
    ram_ce_n_d  = 1'b1;
    ram_oe_n_d  = 1'b1;
    ram_we_n_d  = 1'b1;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
`ifdef ROUND_ROBIN_EN
    grant_last_d = grant_last_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_dm) begin
          port_d      = PORT_DM;
          ram_addr_d  = bus.dm_addr[ADDR_W+1:2];
          ram_wdata_d = bus.dm_wdata;
          ram_be_n_d  = bus.dm_sel_n;
          state_d     = bus.dm_we_n ? RD : WR;
          cnt_d       = '0;
`ifdef ROUND_ROBIN_EN
          grant_last_d = PORT_DM;
`endif
        end else if (grant_if) begin
          port_d      = PORT_IF;
          ram_addr_d  = bus.if_addr[ADDR_W+1:2];
          ram_be_n_d  = 4'b0000;
          state_d     = RD;
          cnt_d       = '0;
`ifdef ROUND_ROBIN_EN
          grant_last_d = PORT_IF;
`endif
        end
      end

      // Data is sampled at the end of the last access cycle; ack follows.
      RD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (port_q == PORT_DM) begin
            dm_rdata_d = bus.ram_rdata;
            dm_ack_d   = 1'b1;
          end else begin
            if_rdata_d = bus.ram_rdata;
            if_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = WR_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Only the data port can write.
      WR_HOLD: begin
        state_d  = IDLE;
        cnt_d    = '0;
        dm_ack_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // SRAM control pins follow the state being entered.
    unique case (state_d)
      IDLE: begin
        ram_be_n_d = 4'b1111;
      end
      RD: begin
        ram_ce_n_d = 1'b0;
        ram_oe_n_d = 1'b0;
      end
      WR: begin
        ram_ce_n_d = 1'b0;
        ram_we_n_d = 1'b0;
      end
      WR_HOLD: begin
        ram_ce_n_d = 1'b0;
      end
      default: begin
        ram_be_n_d = 4'b1111;
      end
    endcase
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_be_n  = ram_be_n_q;
  assign bus.ram_ce_n  = ram_ce_n_q;
  assign bus.ram_oe_n  = ram_oe_n_q;
  assign bus.ram_we_n  = ram_we_n_q;

  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

  assign bus.if_stall  = bus.if_req & ~if_ack_q;
  assign bus.dm_stall  = bus.dm_ce  & ~dm_ack_q;

endmodule
